// File: rtl/tinysnn_pkg.sv
// Shared sizes, reset constants and helpers for the tiny LIF spiking network tile.
package tinysnn_pkg;

    localparam int N_NEURONS = 4;
    localparam int N_INPUTS  = 8;
    localparam int W_WIDTH   = 4;
    localparam int V_WIDTH   = 8;
    localparam int SUM_WIDTH = 10;

    localparam logic [V_WIDTH-1:0] THRESH_RST = 8'h10;
    localparam logic [V_WIDTH-1:0] LEAK_RST   = 8'h01;

    typedef enum logic [1:0] {
        PADDR_THRESH = 2'd0,
        PADDR_LEAK   = 2'd1,
        PADDR_RSVD2  = 2'd2,
        PADDR_RSVD3  = 2'd3
    } param_addr_e;

    // Saturate a signed intermediate potential into the unsigned membrane range.
    function automatic logic [V_WIDTH-1:0] clamp_v(input logic signed [SUM_WIDTH-1:0] t);
        if (t[SUM_WIDTH-1])
            return '0;
        else if (|t[SUM_WIDTH-2:V_WIDTH])
            return '1;
        else
            return t[V_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/tinysnn_lif_neuron.sv
// One leaky integrate-and-fire neuron: private weight row, weighted sum, leak/clamp,
// threshold compare and the membrane/spike registers.
module tinysnn_lif_neuron
    import tinysnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cfg_mode,
    input  logic                 w_we,
    input  logic [1:0]           w_pair,
    input  logic [7:0]           w_data,
    input  logic [N_INPUTS-1:0]  spikes,
    input  logic [V_WIDTH-1:0]   threshold,
    input  logic [V_WIDTH-1:0]   leak,
    output logic [V_WIDTH-1:0]   v,
    output logic                 spk
);

    logic signed [W_WIDTH-1:0]   w [N_INPUTS];
    logic signed [SUM_WIDTH-1:0] sum;
    logic signed [SUM_WIDTH-1:0] t;
    logic [V_WIDTH-1:0]          t_clamped;
    logic                        fire;

    // NOTE: combinational accumulation uses blocking '=' so each loop pass sees the previous partial sum.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (spikes[i])
                sum = sum + {{(SUM_WIDTH-W_WIDTH){w[i][W_WIDTH-1]}}, w[i]};
        end
        t         = sum + $signed({2'b00, v}) - $signed({2'b00, leak});
        t_clamped = clamp_v(t);
        fire      = (t_clamped >= threshold);
    end

    // NOTE: the weight array is reset on purpose: all-zero weights after reset are visible behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++)
                w[i] <= '0;
        end else if (ena && w_we) begin
            w[{w_pair, 1'b0}] <= w_data[3:0];
            w[{w_pair, 1'b1}] <= w_data[7:4];
        end
    end

    // NOTE: state registers use non-blocking '<=' so every neuron samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            spk <= 1'b0;
        end else if (ena) begin
            if (cfg_mode) begin
                spk <= 1'b0;
            end else if (fire) begin
                spk <= 1'b1;
                v   <= '0;
            end else begin
                spk <= 1'b0;
                v   <= t_clamped;
            end
        end
    end

endmodule

// File: rtl/irfan_tinysnn.sv
// Tile top: config decoder, shared threshold/leak registers, four LIF neurons and the
// membrane probe mux. Bidirectional pins are inputs only.
module irfan_tinysnn
    import tinysnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic                  cfg_mode;
    logic                  cfg_sel;
    logic [3:0]            cfg_addr;
    logic [V_WIDTH-1:0]    threshold;
    logic [V_WIDTH-1:0]    leak;
    logic [V_WIDTH-1:0]    v [N_NEURONS];
    logic [V_WIDTH-1:0]    v_probe;
    logic [N_NEURONS-1:0]  spk;
    logic [N_NEURONS-1:0]  w_we;
    logic                  unused_bits;

    assign cfg_mode = uio_in[7];
    assign cfg_sel  = uio_in[6];
    assign cfg_addr = uio_in[3:0];

    // NOTE: defaulting w_we before the loop keeps this block free of inferred latches.
    always_comb begin
        w_we = '0;
        for (int n = 0; n < N_NEURONS; n++)
            w_we[n] = cfg_mode && !cfg_sel && (cfg_addr[3:2] == 2'(n));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold <= THRESH_RST;
            leak      <= LEAK_RST;
        end else if (ena && cfg_mode && cfg_sel) begin
            case (param_addr_e'(cfg_addr[1:0]))
                PADDR_THRESH: threshold <= ui_in;
                PADDR_LEAK:   leak      <= ui_in;
                default:      ;
            endcase
        end
    end

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        tinysnn_lif_neuron u_neuron (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena),
            .cfg_mode  (cfg_mode),
            .w_we      (w_we[n]),
            .w_pair    (cfg_addr[1:0]),
            .w_data    (ui_in),
            .spikes    (ui_in),
            .threshold (threshold),
            .leak      (leak),
            .v         (v[n]),
            .spk       (spk[n])
        );
    end

    // Probe select shares uio_in[1:0] with the config address; it is a live mux, not registered.
    assign v_probe     = v[uio_in[1:0]];
    assign uo_out      = {v_probe[7:4], spk};
    assign uio_out     = '0;
    assign uio_oe      = '0;
    assign unused_bits = ^{uio_in[5:4], v_probe[3:0]};

endmodule

// File: tb/tb_irfan_tinysnn.sv
// Scoreboard bench for irfan_tinysnn: the driver pushes the expected uo_out from a
// behavioural integer model, a separate monitor pops and compares every cycle.
module tb_irfan_tinysnn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    irfan_tinysnn dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state in plain integers.
    int m_w [4][8];
    int m_thr;
    int m_leak;
    int m_v [4];
    int m_spk [4];

    typedef struct {
        logic [7:0] uo;
        int         seq;
    } exp_t;

    exp_t exp_q[$];
    int   seq_no     = 0;
    bit [1:0] last_probe = 2'd0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx4(input bit [3:0] x);
        return (x > 4'd7) ? int'(x) - 16 : int'(x);
    endfunction

    function automatic void model_reset();
        foreach (m_w[n, i]) m_w[n][i] = 0;
        for (int n = 0; n < 4; n++) begin
            m_v[n]   = 0;
            m_spk[n] = 0;
        end
        m_thr  = 16;
        m_leak = 1;
    endfunction

    // Effect of one rising edge given the inputs held across it.
    function automatic void model_edge(input bit en, input bit [7:0] ui, input bit [7:0] uio);
        int n;
        int p;
        int sum;
        int t;
        if (!en) return;
        if (uio[7]) begin
            if (!uio[6]) begin
                n = int'(uio[3:2]);
                p = int'(uio[1:0]);
                m_w[n][2*p]   = sx4(ui[3:0]);
                m_w[n][2*p+1] = sx4(ui[7:4]);
            end else if (uio[1:0] == 2'd0) begin
                m_thr = int'(ui);
            end else if (uio[1:0] == 2'd1) begin
                m_leak = int'(ui);
            end
            for (int k = 0; k < 4; k++) m_spk[k] = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                sum = 0;
                for (int i = 0; i < 8; i++)
                    if (ui[i]) sum += m_w[k][i];
                t = m_v[k] + sum - m_leak;
                if (t < 0)   t = 0;
                if (t > 255) t = 255;
                if (t >= m_thr) begin
                    m_spk[k] = 1;
                    m_v[k]   = 0;
                end else begin
                    m_spk[k] = 0;
                    m_v[k]   = t;
                end
            end
        end
    endfunction

    function automatic logic [7:0] model_uo(input bit [1:0] probe);
        logic [7:0] r;
        r = 8'((m_v[probe] / 16) * 16);
        for (int k = 0; k < 4; k++)
            if (m_spk[k] != 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic step(input bit en, input bit [7:0] ui, input bit [7:0] uio);
        exp_t e;
        @(negedge clk);
        #1;
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        last_probe = uio[1:0];
        model_edge(en, ui, uio);
        @(posedge clk);
        #1;
        e.uo  = model_uo(uio[1:0]);
        e.seq = seq_no++;
        exp_q.push_back(e);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("uo_out#%0d", e.seq), uo_out, e.uo);
                check($sformatf("uio_out#%0d", e.seq), uio_out, 8'h00);
                check($sformatf("uio_oe#%0d", e.seq), uio_oe, 8'h00);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit [7:0] ui;
        bit [7:0] uio;
        bit [3:0] addr;
        bit       sel;
        int       r;

        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        #2;
        check("por_uo_out", uo_out, 8'h00);
        check("por_uio_oe", uio_oe, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Integrate and fire: w[0][0]=+7, V0 6,12,18 -> spike.
        step(1'b1, 8'h07, 8'h80);
        repeat (3) step(1'b1, 8'h01, 8'h00);

        // Leak down from V0=12 to 0 and stay there.
        repeat (2) step(1'b1, 8'h01, 8'h00);
        repeat (14) step(1'b1, 8'h00, 8'h00);

        // Negative weight clamp: w[1][7]=-8, V1 stays 0.
        step(1'b1, 8'h80, 8'h87);
        repeat (4) step(1'b1, 8'h80, 8'h01);

        // Threshold 0 fires every neuron each run cycle, config mode clears spikes.
        step(1'b1, 8'h00, 8'hC0);
        repeat (4) step(1'b1, 8'($urandom), {6'd0, 2'($urandom)});
        step(1'b1, 8'h5A, 8'hC2);
        step(1'b1, 8'hFF, 8'hC3);
        step(1'b1, 8'h10, 8'hC0);

        // Enable gating with firing inputs and attempted writes.
        step(1'b1, 8'h77, 8'h80);
        step(1'b1, 8'h03, 8'h00);
        step(1'b0, 8'hFF, 8'h80);
        step(1'b0, 8'h00, 8'hC0);
        step(1'b0, 8'hFF, 8'hC4);
        step(1'b0, 8'h03, 8'h00);
        step(1'b1, 8'h03, 8'h00);
        step(1'b1, 8'h03, 8'h00);

        // Randomised mix of run, config and gated cycles with a mid-run reset.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            r = $urandom_range(0, 9);
            if (r == 0) begin
                sel  = 1'($urandom);
                addr = 4'($urandom);
                if (!sel)                    ui = 8'($urandom);
                else if (addr[1:0] == 2'd0)  ui = 8'($urandom_range(4, 60));
                else if (addr[1:0] == 2'd1)  ui = 8'($urandom_range(0, 4));
                else                         ui = 8'($urandom);
                uio = {1'b1, sel, 2'($urandom), addr};
                step(1'b1, ui, uio);
            end else if (r == 1) begin
                step(1'b0, 8'($urandom), {2'($urandom), 4'($urandom), last_probe});
            end else begin
                step(1'b1, 8'($urandom), {6'd0, 2'($urandom)});
            end
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
